// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC widths, reset PC, HLT opcode and fetch state type
package sisc_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
    localparam int FIFO_W  = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [5:0]        HLT_OPCODE       = 6'h3F;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sisc_fetch_fifo.sv
// rtl/sisc_fetch_fifo.sv - DEPTH-entry prefetch buffer of {pc, instr} with push/pop/flush
module sisc_fetch_fifo
    import sisc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [FIFO_W-1:0] i_wdata,
    output logic [FIFO_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FIFO_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/sisc_fetch.sv
// rtl/sisc_fetch.sv - SISC fetch unit: PC, run/halt FSM, prefetch buffer; SISC_FETCH_PERF_EN adds counters
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
`ifdef SISC_FETCH_PERF_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count,
`endif
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic              w_fetch_en;
    logic [ADDR_W-1:0] r_pc;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic [FIFO_W-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // halt suppresses the fetch of its own cycle as well as all later ones.
    always_comb begin
        w_state_next = r_state;
        w_fetch_en   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_fetch_en = !halt && !br_valid;
                if (halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign w_pop  = instr_valid && instr_ready;
    assign w_push = w_fetch_en && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_pc <= RESET_PC;
        end else if (br_valid) begin
            r_pc <= br_target;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    sisc_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_f   (rst_f),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (br_valid),
        .i_wdata ({r_pc, imem_data}),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign imem_addr   = r_pc;
    assign instr_valid = (w_count != '0);
    assign instr_pc    = w_rdata[FIFO_W-1:INSTR_W];
    assign instr       = w_rdata[INSTR_W-1:0];

`ifdef SISC_FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_push && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (instr_valid && !instr_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// tb/tb_sisc_fetch.sv - randomized self-checking bench for sisc_fetch against a queue model
module tb_sisc_fetch;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        br_valid = 1'b0;
    logic [15:0] br_target = '0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef SISC_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [47:0] q[$];
    logic [15:0] m_pc;
    bit          m_halt;
    int          m_fetch;
    int          m_stall;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a < 16'd8) return 32'hA000_0000 + {16'h0000, a};
        return {a ^ 16'h5A5A, a};
    endfunction

    assign imem_data = mem_word(imem_addr);

    sisc_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
`ifdef SISC_FETCH_PERF_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .instr_ready (instr_ready)
    );

    task automatic model_reset();
        q.delete();
        m_pc    = RPC;
        m_halt  = 1'b0;
        m_fetch = 0;
        m_stall = 0;
    endtask

    task automatic do_reset();
        rst_f = 1'b0; instr_ready = 1'b0; br_valid = 1'b0; halt = 1'b0; br_target = '0;
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        model_reset();
    endtask

    // Drives one cycle at a negedge, advances the model across the posedge, returns at next negedge.
    task automatic step(input bit rdy, input bit br, input logic [15:0] tgt, input bit hlt);
        bit pop, push;
        instr_ready = rdy; br_valid = br; br_target = tgt; halt = hlt;
        pop  = (q.size() != 0) && rdy;
        push = !m_halt && !br && !hlt && ((q.size() < DEPTH) || pop);
        if ((q.size() != 0) && !rdy) m_stall++;
        if (push) m_fetch++;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (br) q.delete();
        if (push) q.push_back({m_pc, mem_word(m_pc)});
        if (br) m_pc = tgt;
        else if (push) m_pc = m_pc + 16'd1;
        if (hlt) m_halt = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        #1;
        checks++;
        if ({instr_valid, imem_addr, instr_pc, instr} !== {1'b0, RPC, 16'h0000, 32'h0}) begin
            failures++;
            $display("FAIL reset_values got v=%0b a=%h pc=%h i=%h required v=0 a=%h pc=0 i=0",
                     instr_valid, imem_addr, instr_pc, instr, RPC);
        end
`ifdef SISC_FETCH_PERF_EN
        checks++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got f=%0d s=%0d required 0 0", fetch_count, stall_count);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(c) || instr !== mem_word(16'(c))) begin
                failures++;
                $display("FAIL stream[%0d] got v=%0b pc=%h i=%h required v=1 pc=%h i=%h",
                         c, instr_valid, instr_pc, instr, 16'(c), mem_word(16'(c)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (imem_addr !== 16'(DEPTH) || instr_pc !== 16'h0000 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_full got a=%h pc=%h v=%0b required a=%h pc=0000 v=1",
                     imem_addr, instr_pc, instr_valid, 16'(DEPTH));
        end
`ifdef SISC_FETCH_PERF_EN
        checks++;
        if (stall_count !== 32'(m_stall) || fetch_count !== 32'(m_fetch)) begin
            failures++;
            $display("FAIL backpressure_perf got s=%0d f=%0d required s=%0d f=%0d",
                     stall_count, fetch_count, m_stall, m_fetch);
        end
`endif
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (instr_pc !== 16'(c + 1) || instr !== mem_word(16'(c + 1))) begin
                failures++;
                $display("FAIL backpressure_resume[%0d] got pc=%h required %h", c, instr_pc, 16'(c + 1));
            end
        end
    endtask

    task automatic test_branch_full();
        do_reset();
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL branch_bubble got v=%0b a=%h required v=0 a=0040", instr_valid, imem_addr);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr !== mem_word(16'h0040)) begin
            failures++;
            $display("FAIL branch_target got v=%0b pc=%h required v=1 pc=0040", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc;
        do_reset();
        step(1'b1, 1'b1, 16'hFFFE, 1'b0);
        exp_pc = 16'hFFFE;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL wrap[%0d] got v=%0b pc=%h required v=1 pc=%h", c, instr_valid, instr_pc, exp_pc);
            end
            exp_pc = exp_pc + 16'd1;
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (instr_valid !== (c < 2) || (c < 2 && instr_pc !== 16'(c + 1))) begin
                failures++;
                $display("FAIL halt_drain[%0d] got v=%0b pc=%h required v=%0b pc=%h",
                         c, instr_valid, instr_pc, c < 2, 16'(c + 1));
            end
        end
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0003) begin
            failures++;
            $display("FAIL halt_frozen got v=%0b a=%h required v=0 a=0003", instr_valid, imem_addr);
        end
        do_reset();
        step(1'b1, 1'b1, 16'h0123, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0123) begin
            failures++;
            $display("FAIL halt_branch got v=%0b a=%h required v=0 a=0123", instr_valid, imem_addr);
        end
    endtask

    task automatic test_random();
        bit rdy, br, hlt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) == 0);
            hlt = ($urandom_range(0, 249) == 0);
            if (c % 200 == 199) begin
                do_reset();
            end else begin
                step(rdy, br, 16'($urandom), hlt);
            end
            checks++;
            if (instr_valid !== (q.size() != 0) || imem_addr !== m_pc) begin
                failures++;
                $display("FAIL random_state[%0d] got v=%0b a=%h required v=%0b a=%h",
                         c, instr_valid, imem_addr, q.size() != 0, m_pc);
            end
            if (q.size() != 0) begin
                checks++;
                if ({instr_pc, instr} !== q[0]) begin
                    failures++;
                    $display("FAIL random_head[%0d] got %h required %h", c, {instr_pc, instr}, q[0]);
                end
            end
`ifdef SISC_FETCH_PERF_EN
            checks++;
            if (fetch_count !== 32'(m_fetch) || stall_count !== 32'(m_stall)) begin
                failures++;
                $display("FAIL random_perf[%0d] got f=%0d s=%0d required f=%0d s=%0d",
                         c, fetch_count, stall_count, m_fetch, m_stall);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, '0, 1'b0);
        #2;
        rst_f = 1'b0;
        #1;
        checks++;
        if ({instr_valid, imem_addr, instr_pc, instr} !== {1'b0, RPC, 16'h0000, 32'h0}) begin
            failures++;
            $display("FAIL async_reset got v=%0b a=%h pc=%h i=%h required v=0 a=%h pc=0 i=0",
                     instr_valid, imem_addr, instr_pc, instr, RPC);
        end
        @(negedge clk);
        rst_f = 1'b1;
        model_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RPC || instr !== mem_word(RPC)) begin
            failures++;
            $display("FAIL async_restart got v=%0b pc=%h required v=1 pc=%h", instr_valid, instr_pc, RPC);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_wrap();
        test_halt();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
